// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide.
// One bit per cycle; results published on hi/lo with a done pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   raw_a;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dz_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  logic [WIDTH:0]     m_sum;
  logic [WIDTH:0]     d_sh;
  logic [WIDTH-1:0]   d_dif;
  logic               d_ge;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // op[0]=0 selects the signed variants
  assign a_neg = ~op[0] & srcA[WIDTH-1];
  assign b_neg = ~op[0] & srcB[WIDTH-1];
  assign a_abs = a_neg ? -srcA : srcA;
  assign b_abs = b_neg ? -srcB : srcB;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // acc = {upper, lower}: product halves or {remainder, quotient}
  always_comb begin
    m_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, a_mag} : '0);
    d_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    d_ge  = d_sh >= {1'b0, b_mag};
    d_dif = d_sh[WIDTH-1:0] - b_mag;
    if (is_div) begin
      acc_nx = {(d_ge ? d_dif : d_sh[WIDTH-1:0]),
                acc[WIDTH-2:0], d_ge};
    end else begin
      acc_nx = {m_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_r ? -acc[2*WIDTH-1:WIDTH]
                   : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (dz_op) begin
      res_hi = raw_a;
      res_lo = '1;
    end else if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_op  <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      raw_a  <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= CNT_W'(WIDTH);
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz_op  <= op[1] & (srcB == '0);
            a_mag  <= a_abs;
            b_mag  <= b_abs;
            raw_a  <= srcA;
            acc    <= {{WIDTH{1'b0}},
                       (op[1] ? a_abs : b_abs)};
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt - CNT_W'(1);
        end
        FINISH: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
          dz_q <= dz_op;
        end
        default: ;
      endcase
    end
  end

  // fix-up result is shown during FINISH, then held in hi_q/lo_q
  assign busy     = state != IDLE;
  assign done     = state == FINISH;
  assign hi       = done ? res_hi : hi_q;
  assign lo       = done ? res_lo : lo_q;
  assign div_zero = done ? dz_op : dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed checks of mult_div_unit
// against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  src_a8;
  logic [7:0]  src_b8;
  logic        busy8;
  logic        done8;
  logic        div_zero8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srcA(src_a), .srcB(src_b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8),
    .srcA(src_a8), .srcB(src_b8), .busy(busy8), .done(done8),
    .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  function automatic void model(
    input  logic [1:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] mh,
    output logic [31:0] ml,
    output logic        mz
  );
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic [63:0]        up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    mh = '0;
    ml = '0;
    mz = 1'b0;
    if (o[1] && b == 0) begin
      mz = 1'b1;
      mh = a;
      ml = '1;
    end else begin
      case (o)
        2'd0: begin sp = sa * sb; mh = sp[63:32]; ml = sp[31:0]; end
        2'd1: begin
          up = {32'b0, a} * {32'b0, b};
          mh = up[63:32];
          ml = up[31:0];
        end
        2'd2: begin
          sp = sa / sb; ml = sp[31:0];
          sp = sa % sb; mh = sp[31:0];
        end
        default: begin ml = a / b; mh = a % b; end
      endcase
    end
  endfunction

  task automatic wait_idle;
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(
    input  logic [1:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat
  );
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    start8 = 1'b0; op8 = '0; src_a8 = '0; src_b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_zero); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [9] = '{0, 1, 0, 2, 3, 2, 3, 2, 0};
    logic [31:0] t_a  [9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'd100, 32'h1234, 32'd9,
                              32'h80000000, 32'h80000000};
    logic [31:0] t_b  [9] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                              32'd7, 32'd0, 32'd3, 32'hFFFFFFFF,
                              32'h80000000};
    logic [31:0] t_hi [9] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0,
                              32'hFFFFFFFF, 32'h2, 32'h1234, 32'h0,
                              32'h0, 32'h40000000};
    logic [31:0] t_lo [9] = '{32'hFFFFFFF1, 32'h1, 32'h1, 32'hFFFFFFFD,
                              32'hE, 32'hFFFFFFFF, 32'h3, 32'h80000000,
                              32'h0};
    logic        t_dz [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    int lat;
    for (int i = 0; i < 9; i++) begin
      issue(t_op[i], t_a[i], t_b[i], lat);
      total++; if (lat !== 32) $display("FAIL dir%0d_latency got %0d want 32", i, lat); else passed++;
      total++; if (hi !== t_hi[i]) $display("FAIL dir%0d_hi got %h want %h", i, hi, t_hi[i]); else passed++;
      total++; if (lo !== t_lo[i]) $display("FAIL dir%0d_lo got %h want %h", i, lo, t_lo[i]); else passed++;
      total++; if (div_zero !== t_dz[i]) $display("FAIL dir%0d_dz got %b want %b", i, div_zero, t_dz[i]); else passed++;
    end
  endtask

  task automatic test_busy_window;
    int nbusy = 0;
    int ndone = 0;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = 2'd0; src_a = 32'hFFFFFFFD; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && busy; i++) begin
      nbusy++;
      if (done) ndone++;
      @(posedge clk); #1;
    end
    total++; if (nbusy !== 33) $display("FAIL busy_cycles got %0d want 33", nbusy); else passed++;
    total++; if (ndone !== 1) $display("FAIL done_pulses got %0d want 1", ndone); else passed++;
  endtask

  task automatic test_div_zero;
    int lat;
    issue(2'd2, 32'h1234, 32'd0, lat);
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (div_zero !== 1'b1) $display("FAIL dz_hold got %b want 1", div_zero); else passed++;
    total++; if (hi !== 32'h1234) $display("FAIL hi_hold got %h want 1234", hi); else passed++;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
    end
    total++; if (div_zero !== 1'b0) $display("FAIL dz_clear got %b want 0", div_zero); else passed++;
    total++; if (lo !== 32'd3) $display("FAIL dz_next_lo got %h want 3", lo); else passed++;
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mh;
    logic [31:0] ml;
    logic        mz;
    int          lat;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      model(o, a, b, mh, ml, mz);
      issue(o, a, b, lat);
      total++; if (lat !== 32) $display("FAIL rnd%0d_latency got %0d want 32", n, lat); else passed++;
      total++; if (hi !== mh) $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", n, o, a, b, hi, mh); else passed++;
      total++; if (lo !== ml) $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", n, o, a, b, lo, ml); else passed++;
      total++; if (div_zero !== mz) $display("FAIL rnd%0d_dz got %b want %b", n, div_zero, mz); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a0 = 32'h12345678;
    logic [31:0] b0 = 32'hFEDCBA98;
    logic [31:0] a1 = 32'hDEADBEEF;
    logic [31:0] b1 = 32'h00C0FFEE;
    logic [31:0] mh;
    logic [31:0] ml;
    logic        mz;
    int          early = 0;
    int          lat = 0;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = 2'd0; src_a = a0; src_b = b0;
    @(posedge clk); #1;
    start = 1'b0;
    model(2'd0, a0, b0, mh, ml, mz);
    for (int e = 1; e <= 33; e++) begin
      @(negedge clk);
      start = (e == 5 || e == 33);
      op = 2'($urandom_range(0, 3));
      src_a = $urandom;
      src_b = $urandom;
      @(posedge clk); #1;
      if (e < 32 && done) early++;
      if (e == 32) begin
        total++; if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else passed++;
        total++; if (hi !== mh) $display("FAIL b2b_hi got %h want %h", hi, mh); else passed++;
        total++; if (lo !== ml) $display("FAIL b2b_lo got %h want %h", lo, ml); else passed++;
      end
    end
    total++; if (early !== 0) $display("FAIL b2b_early_done got %0d want 0", early); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_done_start got busy %b want 0", busy); else passed++;
    @(negedge clk);
    start = 1'b1; op = 2'd1; src_a = a1; src_b = b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_restart got busy %b want 1", busy); else passed++;
    model(2'd1, a1, b1, mh, ml, mz);
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 32) $display("FAIL b2b2_latency got %0d want 32", lat); else passed++;
    total++; if (hi !== mh) $display("FAIL b2b2_hi got %h want %h", hi, mh); else passed++;
    total++; if (lo !== ml) $display("FAIL b2b2_lo got %h want %h", lo, ml); else passed++;
  endtask

  task automatic test_reset_abort;
    int ndone = 0;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = 2'd0; src_a = 32'h7; src_b = 32'h9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL abort_hi got %h want 0", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL abort_lo got %h want 0", lo); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL abort_dz got %b want 0", div_zero); else passed++;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    total++; if (ndone !== 0) $display("FAIL abort_no_done got %0d want 0", ndone); else passed++;
  endtask

  task automatic test_width8;
    logic [1:0] o;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] mh;
    logic [7:0] ml;
    logic       mz;
    int         sa;
    int         sb;
    int         r;
    int         lat;
    for (int n = 0; n < 21; n++) begin
      if (n == 0) begin
        o = 2'd0; a = 8'h80; b = 8'h80;
      end else begin
        o = 2'($urandom_range(0, 3));
        a = 8'($urandom);
        b = ($urandom_range(0, 4) == 0) ? 8'h0 : 8'($urandom);
      end
      sa = o[0] ? int'({24'b0, a}) : int'({{24{a[7]}}, a});
      sb = o[0] ? int'({24'b0, b}) : int'({{24{b[7]}}, b});
      mz = 1'b0;
      if (o[1] && b == 0) begin
        mz = 1'b1; mh = a; ml = 8'hFF;
      end else if (o[1]) begin
        r = sa / sb; ml = r[7:0];
        r = sa % sb; mh = r[7:0];
      end else begin
        r = sa * sb; mh = r[15:8]; ml = r[7:0];
      end
      if (n == 0) begin
        total++; if (mh !== 8'h40 || ml !== 8'h00) $display("FAIL w8_model got %h%h want 4000", mh, ml); else passed++;
      end
      @(negedge clk);
      start8 = 1'b1; op8 = o; src_a8 = a; src_b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      total++; if (lat !== 8) $display("FAIL w8_%0d_latency got %0d want 8", n, lat); else passed++;
      total++; if (hi8 !== mh) $display("FAIL w8_%0d_hi op=%0d a=%h b=%h got %h want %h", n, o, a, b, hi8, mh); else passed++;
      total++; if (lo8 !== ml) $display("FAIL w8_%0d_lo op=%0d a=%h b=%h got %h want %h", n, o, a, b, lo8, ml); else passed++;
      total++; if (div_zero8 !== mz) $display("FAIL w8_%0d_dz got %b want %b", n, div_zero8, mz); else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_window();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_width8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
